uart_rx_fifo: RTL and testbench

- Receive-side buffer directly downstream of the UART receiver. Each received byte arrives as a one-cycle strobe and is stored in a circular FIFO.
- The host side pops bytes through a show-ahead read port.
- The block drives the rts flow-control line back toward the link using high/low watermark hysteresis.
- It detects overrun and records the per-byte framing-error status alongside the data.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_fifo_mem.sv | 37 +++
 rtl/uart_rx_fifo.sv | 157 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and default constants for the UART receive
//                path: byte width, FIFO entry layout {ferr, data} and the
//                default FIFO depth / rts watermark settings.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

  localparam int UART_BYTE_W  = 8;
  localparam int UART_ENTRY_W = UART_BYTE_W + 1;

  // Default geometry: 16 entries, rts drops at 12 and returns at 4.
  localparam int UART_DEPTH_LOG2_DEF = 4;
  localparam int UART_HI_WM_DEF      = 12;
  localparam int UART_LO_WM_DEF      = 4;

  // One stored receive entry: framing-error flag above the data byte.
  typedef struct packed {
    logic                   ferr;
    logic [UART_BYTE_W-1:0] data;
  } rx_entry_t;

endpackage
`default_nettype wire

// File: rtl/uart_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : uart_fifo_mem
//  Description : Simple dual-port storage for the receive FIFO.
//                Synchronous write, asynchronous (show-ahead) read, no reset
//                so it maps onto distributed RAM.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int ADDR_W = UART_DEPTH_LOG2_DEF
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  rx_entry_t         i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output rx_entry_t         o_rdata
);

  localparam int c_depth = 1 << ADDR_W;

  rx_entry_t r_mem [c_depth];

  // Write port: store the entry at the write address on an accepted push.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port is combinational so the head entry is always presented.
  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Receive-side byte FIFO behind the UART receiver. Stores
//                {ferr, data} per byte, presents the head byte show-ahead,
//                drives rts with high/low watermark hysteresis and flags
//                overrun when a byte arrives with no room.
//  Options     : UART_RX_FIFO_STATS_EN - when defined, builds a saturating
//                16-bit dropped-byte counter on drop_cnt; otherwise drop_cnt
//                is tied to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = UART_DEPTH_LOG2_DEF,
  parameter int HI_WM      = UART_HI_WM_DEF,
  parameter int LO_WM      = UART_LO_WM_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  input  logic [UART_BYTE_W-1:0] wr_data,
  input  logic                   wr_ferr,
  input  logic                   rd,
  output logic [UART_BYTE_W-1:0] dout,
  output logic                   dout_ferr,
  output logic                   empty,
  output logic                   full,
  output logic [DEPTH_LOG2:0]    count,
  output logic                   rts,
  output logic                   ovr,
  input  logic                   ovr_clr,
  output logic [15:0]            drop_cnt
);

  localparam int                  c_cnt_w  = DEPTH_LOG2 + 1;
  localparam int                  c_depth  = 1 << DEPTH_LOG2;
  localparam logic [c_cnt_w-1:0]  c_depth_v = c_cnt_w'(c_depth);
  localparam logic [c_cnt_w-1:0]  c_hi_wm  = c_cnt_w'(HI_WM);
  localparam logic [c_cnt_w-1:0]  c_lo_wm  = c_cnt_w'(LO_WM);

  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0]    r_count;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_rts;
  logic                  r_ovr;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [c_cnt_w-1:0]    w_count_nxt;
  rx_entry_t             w_wdata;
  rx_entry_t             w_rdata;

  // Accept/drop decisions on registered flags. When full, a same-cycle pop
  // frees the head slot, so the incoming byte is still accepted. When empty,
  // a read is ignored even if a byte is arriving (no fall-through).
  always_comb begin
    w_pop       = rd & ~r_empty;
    w_push      = wr_valid & (~r_full | w_pop);
    w_drop      = wr_valid & r_full & ~w_pop;
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  assign w_wdata = '{ferr: wr_ferr, data: wr_data};

  uart_fifo_mem #(
    .ADDR_W (DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Pointers, occupancy and registered empty/full derived from next count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == c_depth_v);
    end
  end

  // rts hysteresis: drop at the high watermark, return at the low one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rts <= 1'b1;
    end else if (r_rts && (w_count_nxt >= c_hi_wm)) begin
      r_rts <= 1'b0;
    end else if (!r_rts && (w_count_nxt <= c_lo_wm)) begin
      r_rts <= 1'b1;
    end
  end

  // Sticky overrun; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovr <= 1'b0;
    end else if (w_drop) begin
      r_ovr <= 1'b1;
    end else if (ovr_clr) begin
      r_ovr <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_STATS_EN
  logic [15:0] r_drop_cnt;

  // Saturating dropped-byte counter; a clear coinciding with a drop leaves 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (ovr_clr) begin
      r_drop_cnt <= {15'd0, w_drop};
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = 16'h0000;
`endif

  assign dout      = w_rdata.data;
  assign dout_ferr = w_rdata.ferr;
  assign empty     = r_empty;
  assign full      = r_full;
  assign count     = r_count;
  assign rts       = r_rts;
  assign ovr       = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Self-checking bench for uart_rx_fifo. A reference queue
//                holds expected bytes; pops are compared against its head.
//                A small vector table covers the basic push/pop cases and
//                hand-written sequences cover watermarks, overrun, full and
//                empty collisions, pointer wrap and asynchronous reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ferr;
  logic        rd;
  logic [7:0]  dout;
  logic        dout_ferr;
  logic        empty;
  logic        full;
  logic [4:0]  count;
  logic        rts;
  logic        ovr;
  logic        ovr_clr;
  logic [15:0] drop_cnt;

  uart_rx_fifo #(
    .DEPTH_LOG2 (4),
    .HI_WM      (12),
    .LO_WM      (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ferr   (wr_ferr),
    .rd        (rd),
    .dout      (dout),
    .dout_ferr (dout_ferr),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .rts       (rts),
    .ovr       (ovr),
    .ovr_clr   (ovr_clr),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       ferr;
    logic [7:0] data;
  } ent_t;

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       wf;
    logic       rd;
    logic       oc;
    logic [4:0] e_count;
    logic       e_empty;
    logic       e_rts;
    logic       e_chk_dout;
    logic [7:0] e_dout;
    logic       e_ferr;
  } vec_t;

  ent_t  sb[$];
  vec_t  tbl[5];
  int    n_total;
  int    n_pass;
  logic  m_rts;
  logic  m_ovr;
  int    m_dc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the reference model advances alongside the DUT.
  task automatic step(input logic wv, input logic [7:0] wd, input logic wf,
                      input logic r, input logic oc);
    logic m_pop;
    logic m_full;
    logic m_push;
    logic m_drop;
    int   n;
    @(negedge clk);
    wr_valid = wv;
    wr_data  = wd;
    wr_ferr  = wf;
    rd       = r;
    ovr_clr  = oc;
    #1;
    m_pop  = r && (sb.size() > 0);
    m_full = (sb.size() == 16);
    m_push = wv && (!m_full || m_pop);
    m_drop = wv && m_full && !m_pop;
    if (m_pop) begin
      chk("pop_data", 32'(dout), 32'(sb[0].data));
      chk("pop_ferr", 32'(dout_ferr), 32'(sb[0].ferr));
      void'(sb.pop_front());
    end
    @(posedge clk);
    #1;
    if (m_push) sb.push_back({wf, wd});
    n = sb.size();
    if (m_drop) m_ovr = 1'b1;
    else if (oc) m_ovr = 1'b0;
`ifdef UART_RX_FIFO_STATS_EN
    if (oc) m_dc = m_drop ? 1 : 0;
    else if (m_drop && m_dc != 65535) m_dc = m_dc + 1;
`endif
    if (m_rts && n >= 12) m_rts = 1'b0;
    else if (!m_rts && n <= 4) m_rts = 1'b1;
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == 16));
    chk("rts", 32'(rts), 32'(m_rts));
    chk("ovr", 32'(ovr), 32'(m_ovr));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_dc));
    wr_valid = 1'b0;
    rd       = 1'b0;
    ovr_clr  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    n_total  = 0;
    n_pass   = 0;
    m_rts    = 1'b1;
    m_ovr    = 1'b0;
    m_dc     = 0;
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    wr_ferr  = 1'b0;
    rd       = 1'b0;
    ovr_clr  = 1'b0;

    //            wv    wd     wf    rd    oc    cnt   emp   rts   chkd  dout   ferr
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[3] = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 5'd1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rts", 32'(rts), 32'd1);
    chk("rst_ovr", 32'(ovr), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);

    // Vector table: single push/pop, rd on empty, empty push+rd collision.
    for (int i = 0; i < 5; i++) begin
      step(tbl[i].wv, tbl[i].wd, tbl[i].wf, tbl[i].rd, tbl[i].oc);
      chk("tbl_count", 32'(count), 32'(tbl[i].e_count));
      chk("tbl_empty", 32'(empty), 32'(tbl[i].e_empty));
      chk("tbl_rts", 32'(rts), 32'(tbl[i].e_rts));
      if (tbl[i].e_chk_dout) begin
        chk("tbl_dout", 32'(dout), 32'(tbl[i].e_dout));
        chk("tbl_dout_ferr", 32'(dout_ferr), 32'(tbl[i].e_ferr));
      end
    end

    // Watermarks: 12 pushes drop rts, 8 pops bring it back at count 4.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      chk("rts_fill", 32'(rts), 32'(i < 11));
    end
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("rts_drain", 32'(rts), 32'(k >= 7));
    end
    for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Overrun: fill to 16, then a byte with no pop is dropped.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk("ovr_full", 32'(full), 32'd1);
    chk("ovr_set", 32'(ovr), 32'd1);
    chk("ovr_count", 32'(count), 32'd16);
    chk("ovr_head", 32'(dout), 32'h00);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovr_clr", 32'(ovr), 32'd0);
    chk("ovr_clr_dc", 32'(drop_cnt), 32'd0);
    step(1'b1, 8'hE1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hE2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hE3, 1'b0, 1'b0, 1'b1);
    chk("ovr_set_wins", 32'(ovr), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Full collision: push and pop together, 8'h77 comes out last.
    step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    chk("full_both_count", 32'(count), 32'd16);
    chk("full_both_ovr", 32'(ovr), 32'd0);
    for (int k = 0; k < 15; k++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("last_is_77", 32'(dout), 32'h77);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Pointer wrap with interleaved pops.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(8'h40 + i), 1'(i % 5 == 0), 1'(i % 3 == 2), 1'b0);
    end

    // Asynchronous reset mid-stream, checked before the next clock edge.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_rts", 32'(rts), 32'd1);
    chk("arst_full", 32'(full), 32'd0);
    sb.delete();
    m_rts = 1'b1;
    m_ovr = 1'b0;
    m_dc  = 0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
